// File: rtl/logic_unit_pkg.sv
// ============================================================================
// Module      : logic_unit_pkg
// Description : Shared opcodes, state encodings and decode helpers for the
//               logic-unit sequencing front-end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_unit_pkg;

    // Request opcodes
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    // Sequencer states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_HOLD   = 2'd2;

    // Settle counter width: covers the legal SETTLE_CYCLES range 1..15
    localparam int SETTLE_CNT_W = 4;

    // True when the opcode takes its result from the OR/NOR unit
    function automatic logic op_selects_or(input logic [1:0] op);
        return (op == OP_OR) || (op == OP_NOR);
    endfunction

    // True when the unit should produce the non-inverted function
    function automatic logic op_true_polarity(input logic [1:0] op);
        logic pol;
        case (op)
            OP_AND, OP_OR:   pol = 1'b1;
            OP_NAND, OP_NOR: pol = 1'b0;
            default:         pol = 1'b0;
        endcase
        return pol;
    endfunction

endpackage

`default_nettype wire

// File: rtl/logic_unit_driver_settle_counter.sv
// ============================================================================
// Module      : settle_counter
// Description : Loadable down-counter that stops at zero and flags done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_counter #(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_value,
    input  logic               enable,
    output logic               done
);

    logic [COUNT_W-1:0] count;

    // Load takes priority; otherwise count down while enabled, saturating at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/logic_unit_driver.sv
// ============================================================================
// Module      : logic_unit_driver
// Description : Valid/ready sequencing front-end for the 32-bit AND/NAND and
//               OR/NOR combinational units. Launches registered operands,
//               waits a fixed settle time, captures the selected result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_driver
    import logic_unit_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic             lu_andflag,
    output logic             lu_orflag,
    input  logic [WIDTH-1:0] and_out,
    input  logic [WIDTH-1:0] or_out
);

    generate
        if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle_cycles
            $error("logic_unit_driver: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    // Counter is loaded with SETTLE_CYCLES-1 so capture lands SETTLE_CYCLES clocks after accept
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic       sel_or;
    logic       settle_done;
    logic       accept;
    logic       rsp_fire;
    logic       capture;
    logic [WIDTH-1:0] selected_result;

    assign accept          = req_valid & req_ready;
    assign rsp_fire        = rsp_valid & rsp_ready;
    assign capture         = (state == ST_SETTLE) && settle_done;
    assign selected_result = sel_or ? or_out : and_out;

    settle_counter #(
        .COUNT_W    (SETTLE_CNT_W)
    ) u_settle_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (accept),
        .load_value (SETTLE_LOAD),
        .enable     (state == ST_SETTLE),
        .done       (settle_done)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a HOLD handshake with a concurrent accept goes straight back to SETTLE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    next_state = accept ? ST_SETTLE : ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs; req_ready is masked while reset is held so nothing is accepted in reset
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: req_ready = reset_n;
            ST_HOLD: begin
                req_ready = rsp_ready & reset_n;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand launch registers feeding both units; held until the next accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lu_a       <= '0;
            lu_b       <= '0;
            sel_or     <= 1'b0;
            lu_andflag <= 1'b0;
            lu_orflag  <= 1'b0;
        end else if (accept) begin
            lu_a       <= req_a;
            lu_b       <= req_b;
            sel_or     <= op_selects_or(req_op);
            lu_andflag <= op_true_polarity(req_op);
            lu_orflag  <= op_true_polarity(req_op);
        end
    end

    // Result capture; unit outputs are only looked at on the final settle clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else if (capture) begin
            rsp_result <= selected_result;
            rsp_zero   <= (selected_result == '0);
        end
    end

    // Completed-response counter, wraps silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_count <= '0;
        end else if (rsp_fire) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_driver.sv
// ============================================================================
// Module      : tb_logic_unit_driver
// Description : Self-checking bench for logic_unit_driver with behavioural
//               AND/NAND and OR/NOR units on the lu_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_driver;

    localparam int WIDTH  = 32;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic [CNT_W-1:0] op_count;
    logic [WIDTH-1:0] lu_a;
    logic [WIDTH-1:0] lu_b;
    logic             lu_andflag;
    logic             lu_orflag;
    logic [WIDTH-1:0] and_out;
    logic [WIDTH-1:0] or_out;

    logic_unit_driver #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .op_count   (op_count),
        .lu_a       (lu_a),
        .lu_b       (lu_b),
        .lu_andflag (lu_andflag),
        .lu_orflag  (lu_orflag),
        .and_out    (and_out),
        .or_out     (or_out)
    );

    // Stand-ins for the full32BitAnd / full32BitOr gate units
    assign and_out = lu_andflag ? (lu_a & lu_b) : ~(lu_a & lu_b);
    assign or_out  = lu_orflag  ? (lu_a | lu_b) : ~(lu_a | lu_b);

    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int accept_cyc  = 0;
    int model_count = 0;
    logic             prev_valid  = 1'b0;
    logic [WIDTH-1:0] last_result = '0;
    logic [WIDTH:0]   exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp_result;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [1:0] op);
        logic [WIDTH-1:0] r;
        r = op[1] ? (a | b) : (a & b);
        if (op[0]) r = ~r;
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: push at request accept, pop and compare at response handshake
    always @(negedge clk) begin
        logic [WIDTH:0]   e;
        logic [WIDTH-1:0] r;
        if (!reset_n) begin
            exp_q.delete();
            model_count = 0;
            prev_valid  = 1'b0;
        end else begin
            if (rsp_valid && !prev_valid)
                check("latency", 64'(cyc - accept_cyc), 64'(SETTLE + 1));
            prev_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_without_request", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", 64'(rsp_result), 64'(e[WIDTH-1:0]));
                    check("rsp_zero", 64'(rsp_zero), 64'(e[WIDTH]));
                    last_result = rsp_result;
                end
                model_count++;
            end
            if (req_valid && req_ready) begin
                r = model(req_a, req_b, req_op);
                exp_q.push_back({(r == '0), r});
                accept_cyc = cyc;
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic acc;
        acc       = 1'b0;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("accept_within_budget", 64'(acc), 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_within_budget", 64'(exp_q.size() == 0 && !rsp_valid), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'hF0F0_0000, 32'h0F0F_0000, 2'b10, 32'hFFFF_0000, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h1234_5678, 32'h0F0F_0F0F, 2'b00, 32'h0204_0608, 1'b0};
        vecs[4] = '{32'hAAAA_AAAA, 32'h5555_5555, 2'b00, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 2'b01, 32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 2'b10, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'h0000_0001, 32'h0000_0000, 2'b11, 32'hFFFF_FFFE, 1'b0};

        // Reset held with a pending request: nothing may be accepted
        reset_n   = 1'b0;
        req_valid = 1'b1;
        req_a     = vecs[0].a;
        req_b     = vecs[0].b;
        req_op    = vecs[0].op;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_req_ready", 64'(req_ready), 64'd0);
            check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
            check("reset_rsp_result", 64'(rsp_result), 64'd0);
            check("reset_rsp_zero", 64'(rsp_zero), 64'd0);
            check("reset_op_count", 64'(op_count), 64'd0);
            check("reset_lu_a", 64'(lu_a), 64'd0);
            check("reset_lu_b", 64'(lu_b), 64'd0);
            check("reset_flags", 64'({lu_andflag, lu_orflag}), 64'd0);
        end
        reset_n = 1'b1;

        // Table-driven single operations
        for (int v = 0; v < 8; v++) begin
            do_op(vecs[v].a, vecs[v].b, vecs[v].op);
            wait_idle();
            check("table_result", 64'(last_result), 64'(vecs[v].exp_result));
            check("table_zero", 64'(last_result == '0), 64'(vecs[v].exp_zero));
        end
        check("op_count_after_table", 64'(op_count), 64'd8);

        // Response back-pressure with a new request waiting
        rsp_ready = 1'b0;
        do_op(32'hDEAD_0000, 32'h0000_BEEF, 2'b10);
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
        req_a     = 32'h0000_0001;
        req_b     = 32'h0000_0003;
        req_op    = 2'b00;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_rsp_result", 64'(rsp_result), 64'hDEAD_BEEF);
            check("hold_lu_a", 64'(lu_a), 64'hDEAD_0000);
            check("hold_rsp_valid_stays", 64'(rsp_valid), 64'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("b2b_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b_lu_a", 64'(lu_a), 64'd1);
        wait_idle();
        check("b2b_result", 64'(last_result), 64'd1);

        // Reset asserted mid-settle discards the operation
        do_op(32'h1111_0000, 32'h0000_2222, 2'b10);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
            check("midreset_op_count", 64'(op_count), 64'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("postreset_no_rsp", 64'(rsp_valid), 64'd0);
        end
        do_op(32'h0000_00F0, 32'h0000_00FF, 2'b00);
        wait_idle();
        check("postreset_result", 64'(last_result), 64'h0000_00F0);
        check("postreset_op_count", 64'(op_count), 64'd1);

        // 256 back-to-back operations from a fresh counter
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        req_a     = $urandom();
        req_b     = $urandom();
        req_op    = 2'($urandom_range(3));
        req_valid = 1'b1;
        begin
            int issued;
            int n;
            logic acc;
            issued = 0;
            n      = 0;
            while (issued < 256 && n < 5000) begin
                @(negedge clk);
                acc = req_ready;
                @(posedge clk);
                #1;
                n++;
                check("stream_op_count", 64'(op_count), 64'(model_count[CNT_W-1:0]));
                if (acc) begin
                    issued++;
                    req_a  = $urandom();
                    req_b  = $urandom();
                    req_op = 2'($urandom_range(3));
                end
            end
            req_valid = 1'b0;
            check("stream_issued", 64'(issued), 64'd256);
        end
        wait_idle();
        check("stream_responses", 64'(model_count), 64'd256);
        check("op_count_wrap", 64'(op_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
